// File: rtl/clk_load_sequencer.sv
// Staggered enable/disable of clock-load cell groups so the clock-tree load changes one group
// at a time, with a programmable minimum spacing between consecutive changes.
module clk_load_sequencer #(
    parameter int unsigned NGRP   = 8,
    parameter int unsigned STEP_W = 4
) (
    input  logic              CK,
    input  logic              RN,
    input  logic              REQ,
    input  logic [STEP_W-1:0] STEP,
    output logic [NGRP-1:0]   EN,
    output logic              ACK,
    output logic              IDLE,
    output logic              BUSY
);

    localparam int unsigned LW = $clog2(NGRP + 1);
    localparam logic [LW-1:0] LMAX = LW'(NGRP);

    typedef enum logic [1:0] {StOff, StUp, StFull, StDown} state_e;

    state_e            state_q, state_d;
    logic [LW-1:0]     level_q, level_d;
    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic [NGRP-1:0]   en_q, en_d;
    logic              ack_q, ack_d;
    logic              idle_q, idle_d;
    logic              busy_q, busy_d;
    logic              cnt_zero, can_up, can_dn, inc, dec;

    always_comb begin
        cnt_zero = (cnt_q == '0);
        can_up   = REQ && (level_q != LMAX) && cnt_zero;
        can_dn   = !REQ && (level_q != '0) && cnt_zero;
        inc      = 1'b0;
        dec      = 1'b0;
        level_d  = level_q;
        cnt_d    = cnt_zero ? '0 : cnt_q - STEP_W'(1);

        // A reversal only flips direction; the spacing counter still gates the next step.
        unique case (state_q)
            StOff:  inc = can_up;
            StUp: begin
                inc = can_up;
                dec = can_dn;
            end
            StFull: dec = can_dn;
            StDown: begin
                dec = can_dn;
                inc = can_up;
            end
            default: ;
        endcase

        if (inc) begin
            level_d = level_q + LW'(1);
            cnt_d   = STEP;
        end else if (dec) begin
            level_d = level_q - LW'(1);
            cnt_d   = STEP;
        end

        if (level_d == '0 && !REQ) begin
            state_d = StOff;
        end else if (level_d == LMAX && REQ) begin
            state_d = StFull;
        end else if (REQ) begin
            state_d = StUp;
        end else begin
            state_d = StDown;
        end

        for (int unsigned i = 0; i < NGRP; i++) begin
            en_d[i] = (LW'(i) < level_d);
        end
        ack_d  = (level_d == LMAX);
        idle_d = (state_d == StOff);
        busy_d = (state_d == StUp) || (state_d == StDown);
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= StOff;
            level_q <= '0;
            cnt_q   <= '0;
            en_q    <= '0;
            ack_q   <= 1'b0;
            idle_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            ack_q   <= ack_d;
            idle_q  <= idle_d;
            busy_q  <= busy_d;
        end
    end

    assign EN   = en_q;
    assign ACK  = ack_q;
    assign IDLE = idle_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_clk_load_sequencer.sv
// Bench for clk_load_sequencer: table of per-edge vectors checked through a scoreboard queue,
// plus hand-written sequences for REQ toggling and asynchronous reset mid-ramp.
module tb_clk_load_sequencer;

    logic       CK = 1'b0;
    logic       RN = 1'b0;
    logic       REQ = 1'b0;
    logic [3:0] STEP = 4'd0;
    logic [7:0] EN;
    logic       ACK, IDLE, BUSY;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       req;
        logic [3:0] step;
        logic [7:0] en;
        logic       ack;
        logic       idle;
        logic       busy;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    clk_load_sequencer #(.NGRP(8), .STEP_W(4)) dut (
        .CK   (CK),
        .RN   (RN),
        .REQ  (REQ),
        .STEP (STEP),
        .EN   (EN),
        .ACK  (ACK),
        .IDLE (IDLE),
        .BUSY (BUSY)
    );

    always #5 CK = ~CK;

    initial begin
        #400000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] therm(input int n);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic vec_t mk(input logic req, input logic [3:0] step, input int lvl);
        vec_t v;
        v.req  = req;
        v.step = step;
        v.en   = therm(lvl);
        v.ack  = (lvl == 8);
        v.idle = (lvl == 0) && !req;
        v.busy = req ? (lvl < 8) : (lvl > 0);
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h req=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: each pushed record describes outputs after the following edge.
    always @(posedge CK) begin
        vec_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_en", EN, e.en);
            chk("sb_ack", {7'd0, ACK}, {7'd0, e.ack});
            chk("sb_idle", {7'd0, IDLE}, {7'd0, e.idle});
            chk("sb_busy", {7'd0, BUSY}, {7'd0, e.busy});
        end
    end

    initial begin
        int last_chg;
        logic [7:0] prev_en;

        // 1: idle after reset
        for (int k = 0; k < 10; k++) vecs.push_back(mk(1'b0, 4'd0, 0));
        // 2: ramp up with STEP=3, then hold at full
        for (int k = 0; k <= 28; k++) vecs.push_back(mk(1'b1, 4'd3, k / 4 + 1));
        for (int k = 0; k < 3; k++) vecs.push_back(mk(1'b1, 4'd3, 8));
        // 3: ramp down with STEP=1
        for (int k = 0; k <= 14; k++) vecs.push_back(mk(1'b0, 4'd1, 7 - k / 2));
        for (int k = 0; k < 2; k++) vecs.push_back(mk(1'b0, 4'd1, 0));
        // 4: reversal at EN=07 waits for the counter
        for (int k = 0; k <= 8; k++) vecs.push_back(mk(1'b1, 4'd3, k / 4 + 1));
        for (int k = 9; k <= 20; k++) vecs.push_back(mk(1'b0, 4'd3, 3 - (k - 8) / 4));
        for (int k = 0; k < 4; k++) vecs.push_back(mk(1'b0, 4'd3, 0));

        RN = 1'b0;
        #12;
        chk("rst_en", EN, 8'h00);
        chk("rst_ack", {7'd0, ACK}, 8'd0);
        chk("rst_idle", {7'd0, IDLE}, 8'd1);
        chk("rst_busy", {7'd0, BUSY}, 8'd0);
        @(negedge CK);
        RN = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CK);
            REQ  = vecs[i].req;
            STEP = vecs[i].step;
            sb.push_back(vecs[i]);
        end
        @(negedge CK);
        @(negedge CK);
        chk("sb_drained", 8'(sb.size()), 8'd0);

        // 5: REQ toggles every cycle with STEP=2
        STEP     = 4'd2;
        prev_en  = EN;
        last_chg = -100;
        for (int c = 0; c < 40; c++) begin
            @(negedge CK);
            REQ = (c % 2 == 0);
            @(posedge CK);
            #2;
            if (EN !== prev_en) begin
                chk("toggle_spacing", {7'd0, (c - last_chg) >= 3}, 8'd1);
                last_chg = c;
                prev_en  = EN;
            end
            chk("toggle_ack", {7'd0, ACK}, 8'd0);
            chk("toggle_range", {7'd0, (EN == 8'h00) || (EN == 8'h01) || (EN == 8'h03)}, 8'd1);
        end
        chk("toggle_moved", {7'd0, last_chg >= 0}, 8'd1);

        // 6: asynchronous reset mid-ramp, then restart
        @(negedge CK);
        REQ  = 1'b0;
        STEP = 4'd0;
        for (int c = 0; c < 6; c++) @(negedge CK);
        REQ = 1'b1;
        for (int c = 0; c < 5; c++) @(negedge CK);
        chk("ramp_1f", EN, 8'h1f);
        #2;
        RN = 1'b0;
        #1;
        chk("arst_en", EN, 8'h00);
        chk("arst_ack", {7'd0, ACK}, 8'd0);
        chk("arst_busy", {7'd0, BUSY}, 8'd0);
        chk("arst_idle", {7'd0, IDLE}, 8'd1);
        @(negedge CK);
        RN = 1'b1;
        @(posedge CK);
        #2;
        chk("restart_en", EN, 8'h01);
        chk("restart_busy", {7'd0, BUSY}, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
